// File: rtl/flagi_stos.sv
// flagi_stos: hardware stack saving/restoring the C/S/Z/OV/P status flags.
// Optional macro FLAGI_STOS_BLAD_EN enables the sticky overflow/underflow flag.
module flagi_stos #(
  parameter int GLEBOKOSC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic C_in,
  input  logic OV_in,
  input  logic P_in,
  input  logic Z_in,
  input  logic S_in,
  output logic C_out,
  output logic OV_out,
  output logic P_out,
  output logic Z_out,
  output logic S_out,
  output logic przywroc,
  output logic pusty,
  output logic pelny,
  output logic [$clog2(GLEBOKOSC+1)-1:0] liczba,
  output logic blad,
  input  logic blad_kasuj
);

  localparam int LW = $clog2(GLEBOKOSC + 1);
  localparam int IW = $clog2(GLEBOKOSC);

  logic [4:0]    mem [GLEBOKOSC];
  logic [4:0]    wej;
  logic [4:0]    wyj;
  logic [4:0]    top;
  logic [IW-1:0] idx_top;
  logic [IW-1:0] idx_wr;
  logic          ovf;
  logic          udf;

  assign wej     = {C_in, S_in, Z_in, OV_in, P_in};
  assign idx_top = IW'(liczba - LW'(1));
  assign idx_wr  = IW'(liczba);
  assign top     = mem[idx_top];

  assign pusty = (liczba == '0);
  assign pelny = (liczba == LW'(GLEBOKOSC));

  // push+pop on a full stack is a swap, not an overflow
  assign ovf = push & ~pop & pelny;
  assign udf = pop & ~push & pusty;

  assign {C_out, S_out, Z_out, OV_out, P_out} = wyj;

  // stack storage, occupancy and registered restore outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      liczba   <= '0;
      wyj      <= '0;
      przywroc <= 1'b0;
      for (int i = 0; i < GLEBOKOSC; i++)
        mem[i] <= '0;
    end else begin
      przywroc <= 1'b0;
      if (push && pop) begin
        przywroc <= 1'b1;
        if (pusty) begin
          wyj <= wej;
        end else begin
          wyj          <= top;
          mem[idx_top] <= wej;
        end
      end else if (pop && !pusty) begin
        wyj      <= top;
        przywroc <= 1'b1;
        liczba   <= liczba - LW'(1);
      end else if (push && !pelny) begin
        mem[idx_wr] <= wej;
        liczba      <= liczba + LW'(1);
      end
    end
  end

`ifdef FLAGI_STOS_BLAD_EN
  // sticky error: a new event beats a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst)
      blad <= 1'b0;
    else if (ovf || udf)
      blad <= 1'b1;
    else if (blad_kasuj)
      blad <= 1'b0;
  end
`else
  logic [2:0] unused_sig;
  assign unused_sig = {blad_kasuj, ovf, udf};
  assign blad       = 1'b0;
`endif

endmodule

// File: tb/tb_flagi_stos.sv
// tb_flagi_stos: scoreboard bench for flagi_stos (GLEBOKOSC=4).
// Expected restores are queued with the cycle they must appear in.
module tb_flagi_stos;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic C_in = 1'b0, OV_in = 1'b0, P_in = 1'b0, Z_in = 1'b0, S_in = 1'b0;
  logic C_out, OV_out, P_out, Z_out, S_out;
  logic przywroc, pusty, pelny, blad;
  logic blad_kasuj = 1'b0;
  logic [2:0] liczba;

`ifdef FLAGI_STOS_BLAD_EN
  localparam logic BE = 1'b1;
`else
  localparam logic BE = 1'b0;
`endif

  typedef struct {
    int         tag;
    logic [4:0] val;
  } exp_t;

  exp_t exp_q[$];
  int neg_n = 0;
  int checks = 0;
  int errors = 0;

  flagi_stos #(.GLEBOKOSC(4)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .C_in(C_in), .OV_in(OV_in), .P_in(P_in), .Z_in(Z_in), .S_in(S_in),
    .C_out(C_out), .OV_out(OV_out), .P_out(P_out),
    .Z_out(Z_out), .S_out(S_out),
    .przywroc(przywroc), .pusty(pusty), .pelny(pelny),
    .liczba(liczba), .blad(blad), .blad_kasuj(blad_kasuj)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {C_out, S_out, Z_out, OV_out, P_out};
  endfunction

  // monitor: each cycle either a queued restore is due or przywroc must be low
  always @(negedge clk) begin
    exp_t e;
    neg_n++;
    checks++;
    if (exp_q.size() > 0 && exp_q[0].tag == neg_n) begin
      e = exp_q.pop_front();
      if (przywroc !== 1'b1 || outs() !== e.val) begin
        errors++;
        $display("FAIL restore@%0d: przywroc=%b out=%h, required przywroc=1 out=%h",
                 neg_n, przywroc, outs(), e.val);
      end
    end else if (przywroc !== 1'b0) begin
      errors++;
      $display("FAIL strobe@%0d: przywroc=%b out=%h, required przywroc=0",
               neg_n, przywroc, outs());
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // one clock of stimulus; ex queues an expected restore for the next cycle
  task automatic step(input logic ps, input logic pp, input logic [4:0] v,
                      input logic k, input logic r,
                      input logic ex, input logic [4:0] ev);
    push = ps;
    pop  = pp;
    {C_in, S_in, Z_in, OV_in, P_in} = v;
    blad_kasuj = k;
    rst = r;
    if (ex) exp_q.push_back('{tag: neg_n + 2, val: ev});
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    blad_kasuj = 1'b0;
    rst = 1'b0;
  endtask

  task automatic do_push(input logic [4:0] v);
    step(1'b1, 1'b0, v, 1'b0, 1'b0, 1'b0, 5'h00);
  endtask

  task automatic do_pop(input logic ex, input logic [4:0] ev);
    step(1'b0, 1'b1, 5'h00, 1'b0, 1'b0, ex, ev);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 5'h00);
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 5'h00);
    chk("rst_liczba", liczba, 0);
    chk("rst_pusty", pusty, 1);
    chk("rst_pelny", pelny, 0);
    chk("rst_out", outs(), 0);
    chk("rst_blad", blad, 0);

    // single push/pop: C=1,S=0,Z=1,OV=0,P=1
    do_push(5'b10101);
    chk("p1_liczba", liczba, 1);
    chk("p1_pusty", pusty, 0);
    do_pop(1'b1, 5'h15);
    chk("p1_liczba0", liczba, 0);
    chk("p1_pusty1", pusty, 1);
    idle();

    // fill, overflow, then drain back-to-back
    do_push(5'h01);
    do_push(5'h02);
    do_push(5'h04);
    do_push(5'h08);
    chk("full_liczba", liczba, 4);
    chk("full_pelny", pelny, 1);
    do_push(5'h1F);
    chk("ovf_liczba", liczba, 4);
    chk("ovf_blad", blad, int'(BE));
    do_pop(1'b1, 5'h08);
    do_pop(1'b1, 5'h04);
    do_pop(1'b1, 5'h02);
    do_pop(1'b1, 5'h01);
    chk("drain_liczba", liczba, 0);
    chk("drain_pusty", pusty, 1);
    step(1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00);
    chk("kasuj_blad", blad, 0);

    // underflow: no strobe, outputs hold
    do_pop(1'b0, 5'h00);
    chk("udf_out", outs(), 5'h01);
    chk("udf_liczba", liczba, 0);
    chk("udf_blad", blad, int'(BE));
    step(1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00);
    chk("kasuj2_blad", blad, 0);

    // simultaneous push+pop on a non-empty stack
    do_push(5'h01);
    do_push(5'h02);
    do_push(5'h04);
    step(1'b1, 1'b1, 5'h10, 1'b0, 1'b0, 1'b1, 5'h04);
    chk("swap_liczba", liczba, 3);
    do_pop(1'b1, 5'h10);
    do_pop(1'b1, 5'h02);
    do_pop(1'b1, 5'h01);
    chk("swap_liczba0", liczba, 0);

    // simultaneous push+pop on an empty stack bypasses
    step(1'b1, 1'b1, 5'h0A, 1'b0, 1'b0, 1'b1, 5'h0A);
    chk("byp_liczba", liczba, 0);
    chk("byp_pusty", pusty, 1);
    idle();
    chk("byp_hold", outs(), 5'h0A);

    // reset wins over a pop
    do_push(5'h03);
    do_push(5'h05);
    do_push(5'h07);
    step(1'b0, 1'b1, 5'h00, 1'b0, 1'b1, 1'b0, 5'h00);
    chk("rstpop_liczba", liczba, 0);
    chk("rstpop_out", outs(), 0);
    chk("rstpop_pusty", pusty, 1);

    // underflow together with clear: set wins
    step(1'b0, 1'b1, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00);
    chk("setwins_blad", blad, int'(BE));
    chk("setwins_out", outs(), 0);

    idle();
    idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_restore: %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
